// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter sharing one single-port, synchronous-read
// data RAM among NUM_C cores. Each access takes an ISSUE cycle (memory
// strobe) followed by a RESP cycle (ack + read data), so back-to-back
// requesters are served every two cycles.
//
// Optional feature macro: ARB_BURST_EN
//   When defined, a core still requesting in RESP is re-granted up to
//   MAX_BURST consecutive times before arbitration moves on.
//   When undefined, RESP always masks the core just served.

module dm_arbiter #(
    parameter int NUM_C     = 4,
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_C-1:0]    core_en,
    input  logic [NUM_C-1:0]    req,
    input  logic [NUM_C-1:0]    wr,
    input  logic [NUM_C*AW-1:0] addr,
    input  logic [NUM_C*DW-1:0] wdata,
    output logic [NUM_C-1:0]    ack,
    output logic [DW-1:0]       rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata,
    output logic                busy
);

    localparam int GW = (NUM_C > 1) ? $clog2(NUM_C) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     gidx_q, gidx_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    // Write qualifier captured in ISSUE so RESP does not depend on wr staying put.
    logic              we_q, we_d;
`ifdef ARB_BURST_EN
    localparam int BW = $clog2(MAX_BURST) + 1;
    logic [BW-1:0]     burst_q, burst_d;
`endif

    logic [NUM_C-1:0]  elig_s;
    logic [NUM_C-1:0]  gmask_s;
    logic [GW:0]       pick_idle_s;
    logic [GW:0]       pick_resp_s;

    // Round-robin search: first set bit of vec at or above ptr, wrapping.
    // Returns {found, index}.
    function automatic logic [GW:0] rr_pick(input logic [NUM_C-1:0] vec,
                                            input logic [GW-1:0]    ptr);
        logic          found;
        logic [GW-1:0] win;
        int            idx;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_C; k++) begin
            idx = (int'(ptr) + k) % NUM_C;
            if (!found && vec[idx]) begin
                found = 1'b1;
                win   = GW'(idx);
            end else begin
                found = found;
            end
        end
        return {found, win};
    endfunction

    // Priority pointer after a grant: the core just above the winner, wrapping.
    function automatic logic [GW-1:0] next_ptr(input logic [GW-1:0] win);
        logic [GW-1:0] nxt;
        if (win == GW'(NUM_C - 1)) begin
            nxt = '0;
        end else begin
            nxt = win + GW'(1);
        end
        return nxt;
    endfunction

    assign elig_s = req & core_en;
    assign busy   = (state_q != IDLE);

    // Next-state, grant bookkeeping and combinational memory/response outputs.
    always_comb begin
        state_d   = state_q;
        gidx_d    = gidx_q;
        rr_ptr_d  = rr_ptr_q;
        we_d      = we_q;
`ifdef ARB_BURST_EN
        burst_d   = burst_q;
`endif
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ack       = '0;
        rdata     = '0;

        gmask_s          = '0;
        gmask_s[gidx_q]  = 1'b1;
        pick_idle_s      = rr_pick(elig_s, rr_ptr_q);
        pick_resp_s      = rr_pick(elig_s & ~gmask_s, rr_ptr_q);

        case (state_q)
            IDLE: begin
                if (pick_idle_s[GW]) begin
                    gidx_d   = pick_idle_s[GW-1:0];
                    rr_ptr_d = next_ptr(pick_idle_s[GW-1:0]);
                    state_d  = ISSUE;
`ifdef ARB_BURST_EN
                    burst_d  = '0;
`endif
                end else begin
                    state_d  = IDLE;
                end
            end

            ISSUE: begin
                // Committed: completes even if req/core_en of gidx drops now.
                mem_en    = 1'b1;
                mem_we    = wr[gidx_q];
                mem_addr  = addr[int'(gidx_q)*AW +: AW];
                mem_wdata = wdata[int'(gidx_q)*DW +: DW];
                we_d      = wr[gidx_q];
                state_d   = RESP;
            end

            RESP: begin
                ack = gmask_s;
                if (we_q) begin
                    rdata = '0;
                end else begin
                    rdata = mem_rdata;
                end
`ifdef ARB_BURST_EN
                if (elig_s[gidx_q] && (burst_q < BW'(MAX_BURST - 1))) begin
                    burst_d = burst_q + BW'(1);
                    state_d = ISSUE;
                end else begin
                    burst_d = '0;
                    if (pick_resp_s[GW]) begin
                        gidx_d   = pick_resp_s[GW-1:0];
                        rr_ptr_d = next_ptr(pick_resp_s[GW-1:0]);
                        state_d  = ISSUE;
                    end else begin
                        state_d  = IDLE;
                    end
                end
`else
                if (pick_resp_s[GW]) begin
                    gidx_d   = pick_resp_s[GW-1:0];
                    rr_ptr_d = next_ptr(pick_resp_s[GW-1:0]);
                    state_d  = ISSUE;
                end else begin
                    state_d  = IDLE;
                end
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and grant registers; reset drops any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            we_q     <= 1'b0;
`ifdef ARB_BURST_EN
            burst_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            we_q     <= we_d;
`ifdef ARB_BURST_EN
            burst_q  <= burst_d;
`endif
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a small synchronous-read
// RAM model. Core i's default address is 0x0020+i, preloaded with 0xA000+i;
// address 0x0010 holds 0xBEEF.

module tb_dm_arbiter;

    localparam int NUM_C = 4;
    localparam int AW    = 16;
    localparam int DW    = 16;
`ifdef ARB_BURST_EN
    localparam int BL = 4;
`else
    localparam int BL = 1;
`endif

    logic                clk;
    logic                rst;
    logic [NUM_C-1:0]    core_en;
    logic [NUM_C-1:0]    req;
    logic [NUM_C-1:0]    wr;
    logic [NUM_C*AW-1:0] addr;
    logic [NUM_C*DW-1:0] wdata;
    logic [NUM_C-1:0]    ack;
    logic [DW-1:0]       rdata;
    logic                mem_en;
    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic [DW-1:0]       mem_rdata;
    logic                busy;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] ram [256];

    dm_arbiter #(.NUM_C(NUM_C), .AW(AW), .DW(DW), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .core_en   (core_en),
        .req       (req),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int a);
        logic [DW-1:0] v;
        if (a == 16'h0010) v = 16'hBEEF;
        else if (a >= 16'h0020 && a < 16'h0024) v = 16'hA000 + 16'(a - 16'h0020);
        else v = 16'h0000;
        return v;
    endfunction

    // Single-port RAM, one-cycle read latency, reloaded on reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 256; j++) ram[j] <= init_val(j);
            mem_rdata <= 16'h0000;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
            mem_rdata <= ram[mem_addr[7:0]];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect n grants with all listed cores holding req; order from start.
    task automatic run_seq(input string tag, input int start, input int ncore, input int n);
        int e;
        for (int k = 0; k < n; k++) begin
            e = (start + k / BL) % ncore;
            step();
            check_eq({tag, "_mem_en"}, 32'(mem_en), 32'd1);
            check_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'h20 + e);
            check_eq({tag, "_ack_issue"}, 32'(ack), 32'd0);
            step();
            check_eq({tag, "_ack"}, 32'(ack), 32'd1 << e);
            check_eq({tag, "_rdata"}, 32'(rdata), 32'hA000 + e);
        end
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; core_en = 4'h0; req = 4'h0; wr = 4'h0; wdata = '0; addr = '0;
        for (int i = 0; i < NUM_C; i++) addr[i*AW +: AW] = 16'h0020 + 16'(i);
        step();
        step();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_mem_en", 32'(mem_en), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_rdata", 32'(rdata), 32'd0);
        rst = 1'b0; core_en = 4'hF;

        // single read by core 2
        addr[2*AW +: AW] = 16'h0010; req = 4'b0100;
        step();
        check_eq("rd_mem_en", 32'(mem_en), 32'd1);
        check_eq("rd_mem_we", 32'(mem_we), 32'd0);
        check_eq("rd_mem_addr", 32'(mem_addr), 32'h0010);
        check_eq("rd_busy", 32'(busy), 32'd1);
        check_eq("rd_ack_early", 32'(ack), 32'd0);
        step();
        check_eq("rd_ack", 32'(ack), 32'b0100);
        check_eq("rd_rdata", 32'(rdata), 32'hBEEF);
        check_eq("rd_mem_en_off", 32'(mem_en), 32'd0);
        req = 4'b0000; addr[2*AW +: AW] = 16'h0022;
        step();
        check_eq("rd_busy_end", 32'(busy), 32'd0);
        check_eq("rd_ack_end", 32'(ack), 32'd0);

        // single write by core 0, readback by core 1
        addr[0 +: AW] = 16'h0005; wdata[0 +: DW] = 16'h1234; wr = 4'b0001; req = 4'b0001;
        step();
        check_eq("wr_mem_en", 32'(mem_en), 32'd1);
        check_eq("wr_mem_we", 32'(mem_we), 32'd1);
        check_eq("wr_mem_addr", 32'(mem_addr), 32'h0005);
        check_eq("wr_mem_wdata", 32'(mem_wdata), 32'h1234);
        step();
        check_eq("wr_ack", 32'(ack), 32'b0001);
        check_eq("wr_rdata", 32'(rdata), 32'd0);
        check_eq("wr_mem_we_off", 32'(mem_we), 32'd0);
        req = 4'b0000; wr = 4'b0000; addr[0 +: AW] = 16'h0020;
        step();
        addr[AW +: AW] = 16'h0005; req = 4'b0010;
        step();
        check_eq("rb_mem_addr", 32'(mem_addr), 32'h0005);
        check_eq("rb_mem_we", 32'(mem_we), 32'd0);
        step();
        check_eq("rb_ack", 32'(ack), 32'b0010);
        check_eq("rb_rdata", 32'(rdata), 32'h1234);
        req = 4'b0000; addr[AW +: AW] = 16'h0021;
        step();

        // all four requesting from rr_ptr=0 (includes wrap 3 -> 0)
        rst_pulse();
        req = 4'hF;
        run_seq("rr0", 0, 4, 8);
        req = 4'h0;
        step();

        // make rr_ptr=2 by serving core 1, then all four
        rst_pulse();
        req = 4'b0010;
        step();
        step();
        check_eq("p2_ack", 32'(ack), 32'b0010);
        req = 4'h0;
        step();
        check_eq("p2_idle", 32'(busy), 32'd0);
        req = 4'hF;
        run_seq("rr2", 2, 4, 8);
        req = 4'h0;
        step();

        // only cores 0 and 1 enabled
        rst_pulse();
        core_en = 4'b0011; req = 4'hF;
        run_seq("en", 0, 2, 8);
        req = 4'h0;
        step();
        core_en = 4'hF;

        // reset during ISSUE for core 3; still requesting, granted again
        req = 4'b1000;
        step();
        check_eq("rs_mem_addr", 32'(mem_addr), 32'h0023);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rs_busy", 32'(busy), 32'd0);
        check_eq("rs_ack", 32'(ack), 32'd0);
        check_eq("rs_mem_en", 32'(mem_en), 32'd0);
        step();
        check_eq("rs_regrant_en", 32'(mem_en), 32'd1);
        check_eq("rs_regrant_addr", 32'(mem_addr), 32'h0023);
        step();
        check_eq("rs_ack3", 32'(ack), 32'b1000);
        check_eq("rs_rdata3", 32'(rdata), 32'hA003);
        req = 4'h0;
        step();

        // reset clears rr_ptr: grant core 1 (ptr=2), reset, then 0 beats 2
        req = 4'b0010;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; req = 4'b0101;
        step();
        check_eq("ptr_rst_addr", 32'(mem_addr), 32'h0020);
        step();
        check_eq("ptr_rst_ack", 32'(ack), 32'b0001);
        req = 4'h0;
        step();

        // committed access: req and core_en drop during ISSUE
        req = 4'b0001;
        step();
        req = 4'h0; core_en = 4'h0;
        step();
        check_eq("commit_ack", 32'(ack), 32'b0001);
        check_eq("commit_rdata", 32'(rdata), 32'hA000);
        core_en = 4'hF;
        step();
        check_eq("commit_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Round-robin arbiter that shares one single-port, synchronous-read data memory among NUM_C processor cores.
- Each core issues a request/acknowledge transaction. The arbiter sequences one memory access at a time and returns read data to the granted core.
- Sits between the core array (address register, bus and write-enable outputs) and the shared data RAM.
- A core_en mask, driven from the same source as the top-level core-count input, removes inactive cores from arbitration.

Parameters:
- NUM_C, 4, number of requesting cores.
- AW, 16, address width.
- DW, 16, data width.
- MAX_BURST, 4, maximum consecutive grants to one core (used only with ARB_BURST_EN).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- core_en  in  NUM_C  per-core enable; a core whose bit is 0 is never granted.
- req  in  NUM_C  per-core access request; held high until that core's ack.
- wr  in  NUM_C  per-core write (1) / read (0) qualifier.
- addr  in  NUM_C*AW  per-core address; core i occupies bits [i*AW +: AW].
- wdata  in  NUM_C*DW  per-core write data, packed the same way.
- ack  out  NUM_C  one-hot, one-cycle completion pulse.
- rdata  out  DW  read data, valid only when the matching ack bit is high.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid one cycle after mem_en.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- FSM states: IDLE, ISSUE, RESP. gidx (log2 NUM_C bits) records the granted core. rr_ptr records the highest-priority core for the next arbitration.
- Eligibility vector: elig = req & core_en.
- Arbitration: the first set bit of elig found by searching upward from rr_ptr, wrapping modulo NUM_C.
- IDLE:
  - If elig is nonzero, register the winner into gidx, set rr_ptr = (winner+1) mod NUM_C, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly one cycle):
  - mem_en=1, mem_we=wr[gidx], mem_addr=addr[gidx], mem_wdata=wdata[gidx], all driven combinationally from gidx.
  - Always go to RESP.
  - The transaction is committed: if req[gidx] or core_en[gidx] drops during ISSUE, the access still completes.
- RESP (exactly one cycle):
  - ack[gidx]=1.
  - rdata=mem_rdata for reads; rdata=0 for writes.
  - Re-arbitrate with core gidx masked out. If any other core is eligible, latch the new winner, update rr_ptr, go to ISSUE. Otherwise go to IDLE.
- Outside ISSUE: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Outside RESP: ack=0, rdata=0.
- Latency: req rising in IDLE at cycle N gives mem_en at N+1 and ack at N+2.
- Throughput: back-to-back requesters are served every 2 cycles.
- After ack, a core must either drop req or hold it for a new transaction. A request held high is re-arbitrated no earlier than the next IDLE or RESP arbitration.
- Wrap-around: rr_ptr = NUM_C-1 and a winner of NUM_C-1 sets rr_ptr to 0.
- Reset, including mid-transaction: state=IDLE, gidx=0, rr_ptr=0, all outputs 0. Any in-flight access is dropped with no ack.
- Simultaneous requests from all cores: granted strictly in rotating order from rr_ptr. No core waits more than NUM_C-1 grants.

Optional Feature:
- Macro: ARB_BURST_EN.
- Defined:
  - Adds a burst counter (cleared on reset).
  - In RESP, if req[gidx] & core_en[gidx] is still high and the counter < MAX_BURST-1, the same core is re-granted. The counter increments and rr_ptr is unchanged.
  - Otherwise normal masked arbitration resumes and the counter clears.
- Undefined: no burst counter; RESP always masks gidx as described above.

Test Plan:
- Single read: core_en=4'b1111, core 2 reads 0x0010 with memory holding 0xBEEF -> mem_en/mem_addr=0x0010 at N+1; ack=4'b0100 and rdata=0xBEEF at N+2; busy low at N+3.
- Single write: core 0 writes 0x1234 to 0x0005 -> mem_we=1, mem_addr=0x0005, mem_wdata=0x1234 for one cycle; ack=4'b0001 at N+2; readback by core 1 returns 0x1234.
- All four cores hold req with rr_ptr=0 -> ack order 0,1,2,3, one ack every 2 cycles. Repeat with rr_ptr=2 -> order 2,3,0,1.
- core_en=4'b0011 with req=4'b1111 -> only cores 0 and 1 are ever acked, alternating; cores 2 and 3 never see mem_en.
- rst asserted during ISSUE for core 3 -> next cycle state IDLE, ack=0, mem_en=0, rr_ptr=0. Core 3 still requesting is granted again from IDLE.
- ARB_BURST_EN, MAX_BURST=4, cores 0 and 1 both holding req -> core 0 gets 4 consecutive acks, then core 1 gets 4.
